hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the RISC-V 5-stage core. It replaces gated-clock stalling with synchronous stage enables and bubble/flush strobes. It adds a configurable multi-cycle load-use stall, store-data forwarding exemption, branch flush, data-memory wait freeze and a saturating stall-cycle counter. It sits beside the IF/ID and ID/EX registers and drives every pipeline register's enable and flush input.

---
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall FSM, branch flush, data-memory
// wait freeze and a saturating stall-cycle counter for the 5-stage core.
module hazard_ctrl #(
  parameter int AW         = 5,
  parameter int LOAD_STALL = 1,
  parameter int STORE_FWD  = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [AW-1:0]    id_rs1_i,
  input  logic [AW-1:0]    id_rs2_i,
  input  logic             id_rs1_used_i,
  input  logic             id_rs2_used_i,
  input  logic             id_mem_w_i,
  input  logic [AW-1:0]    ex_rd_i,
  input  logic             ex_mem_rd_i,
  input  logic             br_flush_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  input  logic             cnt_clr_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             idex_en_o,
  output logic             exmem_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             memwb_flush_o,
  output logic             load_stall_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic {RUN, LSTALL} state_t;

  localparam logic [1:0]       STALL_INIT = 2'(LOAD_STALL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state, state_nxt;
  logic [1:0] cnt, cnt_nxt;
  logic       m1, m2, hazard, memwait, store_fwd;

  assign store_fwd = (STORE_FWD != 0);
  assign m1        = id_rs1_used_i & (id_rs1_i == ex_rd_i);
  // A store that only needs the load result as write data gets it forwarded later.
  assign m2        = id_rs2_used_i & (id_rs2_i == ex_rd_i)
                     & ~(store_fwd & id_mem_w_i & ~m1);
  assign hazard    = ex_mem_rd_i & (ex_rd_i != '0) & (m1 | m2);
  assign memwait   = mem_req_i & ~mem_ready_i;

  assign load_stall_o = (state == LSTALL);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    idex_en_o     = 1'b1;
    exmem_en_o    = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    memwb_flush_o = 1'b0;
    // A pending branch flush stays frozen in EX during memwait and re-presents afterwards.
    if (memwait) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_en_o    = 1'b0;
      memwb_flush_o = 1'b1;
    end else if (br_flush_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      state_nxt    = RUN;
      cnt_nxt      = '0;
    end else if ((state == RUN && hazard) || state == LSTALL) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
      if (state == RUN) begin
        if (LOAD_STALL > 1) begin
          state_nxt = LSTALL;
          cnt_nxt   = STALL_INIT;
        end
      end else begin
        cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd1) state_nxt = RUN;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt_o <= '0;
    end else if (!pc_en_o && stall_cnt_o != CNT_MAX) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three parameterisations share one stimulus
// stream; a vector table covers combinational decode, sequences cover the FSM.
module tb_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       memw;
    logic [4:0] exrd;
    logic       exld;
    logic       br;
    logic       req;
    logic       rdy;
  } in_t;

  typedef struct packed {
    in_t        stim;
    logic [6:0] exp_a;
    logic [6:0] exp_b;
  } vec_t;

  // Output packing: {pc, ifid, idex, exmem, ifid_flush, idex_flush, memwb_flush}
  localparam logic [6:0] O_RUN   = 7'b1111_000;
  localparam logic [6:0] O_STALL = 7'b0011_010;
  localparam logic [6:0] O_FLUSH = 7'b1111_110;
  localparam logic [6:0] O_WAIT  = 7'b0000_001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, exrd = '0;
  logic       u1 = 1'b0, u2 = 1'b0, memw = 1'b0, exld = 1'b0;
  logic       br = 1'b0, req = 1'b0, rdy = 1'b0, clr = 1'b0;

  logic [6:0]  outs_a, outs_b, outs_c;
  logic        ls_a, ls_b, ls_c;
  logic [15:0] cnt_a, cnt_b;
  logic [3:0]  cnt_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.AW(5), .LOAD_STALL(1), .STORE_FWD(1), .CNT_W(16)) dut_a (
    .clk_i(clk), .reset_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2), .id_mem_w_i(memw),
    .ex_rd_i(exrd), .ex_mem_rd_i(exld), .br_flush_i(br),
    .mem_req_i(req), .mem_ready_i(rdy), .cnt_clr_i(clr),
    .pc_en_o(outs_a[6]), .ifid_en_o(outs_a[5]), .idex_en_o(outs_a[4]),
    .exmem_en_o(outs_a[3]), .ifid_flush_o(outs_a[2]), .idex_flush_o(outs_a[1]),
    .memwb_flush_o(outs_a[0]), .load_stall_o(ls_a), .stall_cnt_o(cnt_a)
  );

  hazard_ctrl #(.AW(5), .LOAD_STALL(1), .STORE_FWD(0), .CNT_W(16)) dut_b (
    .clk_i(clk), .reset_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2), .id_mem_w_i(memw),
    .ex_rd_i(exrd), .ex_mem_rd_i(exld), .br_flush_i(br),
    .mem_req_i(req), .mem_ready_i(rdy), .cnt_clr_i(clr),
    .pc_en_o(outs_b[6]), .ifid_en_o(outs_b[5]), .idex_en_o(outs_b[4]),
    .exmem_en_o(outs_b[3]), .ifid_flush_o(outs_b[2]), .idex_flush_o(outs_b[1]),
    .memwb_flush_o(outs_b[0]), .load_stall_o(ls_b), .stall_cnt_o(cnt_b)
  );

  hazard_ctrl #(.AW(5), .LOAD_STALL(3), .STORE_FWD(1), .CNT_W(4)) dut_c (
    .clk_i(clk), .reset_i(rst), .id_rs1_i(rs1), .id_rs2_i(rs2),
    .id_rs1_used_i(u1), .id_rs2_used_i(u2), .id_mem_w_i(memw),
    .ex_rd_i(exrd), .ex_mem_rd_i(exld), .br_flush_i(br),
    .mem_req_i(req), .mem_ready_i(rdy), .cnt_clr_i(clr),
    .pc_en_o(outs_c[6]), .ifid_en_o(outs_c[5]), .idex_en_o(outs_c[4]),
    .exmem_en_o(outs_c[3]), .ifid_flush_o(outs_c[2]), .idex_flush_o(outs_c[1]),
    .memwb_flush_o(outs_c[0]), .load_stall_o(ls_c), .stall_cnt_o(cnt_c)
  );

  function automatic in_t mkIn(input logic [4:0] r1, input logic [4:0] r2,
                               input logic a1, input logic a2, input logic w,
                               input logic [4:0] rd, input logic ld,
                               input logic b, input logic q, input logic y);
    in_t v;
    v.rs1 = r1; v.rs2 = r2; v.u1 = a1; v.u2 = a2; v.memw = w;
    v.exrd = rd; v.exld = ld; v.br = b; v.req = q; v.rdy = y;
    return v;
  endfunction

  // Inputs change just after the falling edge; checks follow 1 time unit later.
  task automatic applyStimulus(input in_t v);
    @(negedge clk);
    rs1 = v.rs1; rs2 = v.rs2; u1 = v.u1; u2 = v.u2; memw = v.memw;
    exrd = v.exrd; exld = v.exld; br = v.br; req = v.req; rdy = v.rdy;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkC(input string name, input logic [6:0] exp_o,
                        input logic exp_ls);
    checkOutput({name, ".outs"}, 32'(outs_c), 32'(exp_o));
    checkOutput({name, ".ls"}, 32'(ls_c), 32'(exp_ls));
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  in_t  idle, haz;
  vec_t vecs[14];

  initial begin
    idle = mkIn(5'd1, 5'd2, 1, 1, 0, 5'd5, 1, 0, 0, 0);
    haz  = mkIn(5'd5, 5'd2, 1, 1, 0, 5'd5, 1, 0, 0, 0);

    vecs[0]  = '{idle, O_RUN, O_RUN};
    vecs[1]  = '{haz, O_STALL, O_STALL};
    vecs[2]  = '{mkIn(5'd5, 5'd2, 0, 1, 0, 5'd5, 1, 0, 0, 0), O_RUN, O_RUN};
    vecs[3]  = '{mkIn(5'd1, 5'd5, 1, 1, 0, 5'd5, 1, 0, 0, 0), O_STALL, O_STALL};
    vecs[4]  = '{mkIn(5'd2, 5'd7, 1, 1, 1, 5'd7, 1, 0, 0, 0), O_RUN, O_STALL};
    vecs[5]  = '{mkIn(5'd7, 5'd7, 1, 1, 1, 5'd7, 1, 0, 0, 0), O_STALL, O_STALL};
    vecs[6]  = '{mkIn(5'd0, 5'd3, 1, 1, 0, 5'd0, 1, 0, 0, 0), O_RUN, O_RUN};
    vecs[7]  = '{mkIn(5'd5, 5'd2, 1, 1, 0, 5'd5, 0, 0, 0, 0), O_RUN, O_RUN};
    vecs[8]  = '{mkIn(5'd5, 5'd2, 1, 1, 0, 5'd5, 1, 1, 0, 0), O_FLUSH, O_FLUSH};
    vecs[9]  = '{mkIn(5'd5, 5'd2, 1, 1, 0, 5'd5, 1, 0, 1, 0), O_WAIT, O_WAIT};
    vecs[10] = '{mkIn(5'd1, 5'd2, 1, 1, 0, 5'd5, 1, 1, 1, 0), O_WAIT, O_WAIT};
    vecs[11] = '{mkIn(5'd5, 5'd2, 1, 1, 0, 5'd5, 1, 0, 0, 1), O_STALL, O_STALL};
    vecs[12] = '{mkIn(5'd1, 5'd2, 1, 1, 0, 5'd5, 1, 0, 1, 1), O_RUN, O_RUN};
    vecs[13] = '{mkIn(5'd1, 5'd2, 1, 1, 0, 5'd5, 1, 1, 0, 0), O_FLUSH, O_FLUSH};

    // Reset with hazard-free inputs
    applyStimulus(idle);
    rst = 1'b1;
    #1;
    checkOutput("rst.outs_a", 32'(outs_a), 32'(O_RUN));
    checkC("rst.c", O_RUN, 1'b0);
    checkOutput("rst.cnt_a", 32'(cnt_a), 0);
    checkOutput("rst.cnt_c", 32'(cnt_c), 0);
    @(negedge clk);
    rst = 1'b0;

    // Decode table against the two single-cycle-stall instances
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].stim);
      checkOutput($sformatf("vec%0d.a", i), 32'(outs_a), 32'(vecs[i].exp_a));
      checkOutput($sformatf("vec%0d.b", i), 32'(outs_b), 32'(vecs[i].exp_b));
      checkOutput($sformatf("vec%0d.ls_a", i), 32'(ls_a), 0);
    end

    // LOAD_STALL=1: one stall cycle, counter 0 -> 1
    pulseReset();
    applyStimulus(haz);
    checkOutput("ls1.stall", 32'(outs_a), 32'(O_STALL));
    checkOutput("ls1.cnt0", 32'(cnt_a), 0);
    applyStimulus(idle);
    checkOutput("ls1.resume", 32'(outs_a), 32'(O_RUN));
    checkOutput("ls1.cnt1", 32'(cnt_a), 1);

    // LOAD_STALL=3: stall held three cycles regardless of later inputs
    pulseReset();
    applyStimulus(haz);
    checkC("ls3.c1", O_STALL, 1'b0);
    applyStimulus(idle);
    checkC("ls3.c2", O_STALL, 1'b1);
    applyStimulus(idle);
    checkC("ls3.c3", O_STALL, 1'b1);
    applyStimulus(idle);
    checkC("ls3.c4", O_RUN, 1'b0);
    checkOutput("ls3.cnt", 32'(cnt_c), 3);

    // Branch flush in the second stall cycle cancels the stall
    pulseReset();
    applyStimulus(haz);
    checkC("flush.c1", O_STALL, 1'b0);
    applyStimulus(mkIn(5'd1, 5'd2, 1, 1, 0, 5'd5, 1, 1, 0, 0));
    checkC("flush.c2", O_FLUSH, 1'b1);
    applyStimulus(idle);
    checkC("flush.c3", O_RUN, 1'b0);
    applyStimulus(idle);
    checkC("flush.c4", O_RUN, 1'b0);
    checkOutput("flush.cnt", 32'(cnt_c), 1);

    // Memwait during the cnt=2 stall cycle freezes, then stall resumes
    pulseReset();
    applyStimulus(haz);
    checkC("mw.c1", O_STALL, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mkIn(5'd1, 5'd2, 1, 1, 0, 5'd5, 1, 0, 1, 0));
      checkC($sformatf("mw.wait%0d", i), O_WAIT, 1'b1);
    end
    applyStimulus(idle);
    checkC("mw.r1", O_STALL, 1'b1);
    applyStimulus(idle);
    checkC("mw.r2", O_STALL, 1'b1);
    applyStimulus(idle);
    checkC("mw.done", O_RUN, 1'b0);
    checkOutput("mw.cnt", 32'(cnt_c), 7);

    // 4-bit counter saturation and synchronous clear
    pulseReset();
    for (int i = 0; i < 14; i++) applyStimulus(haz);
    applyStimulus(haz);
    checkOutput("sat.cnt14", 32'(cnt_c), 14);
    for (int i = 0; i < 5; i++) applyStimulus(haz);
    applyStimulus(idle);
    checkOutput("sat.cnt15", 32'(cnt_c), 15);
    clr = 1'b1;
    applyStimulus(idle);
    clr = 1'b0;
    applyStimulus(idle);
    checkOutput("sat.clr", 32'(cnt_c), 0);

    // Asynchronous reset in the middle of LSTALL
    pulseReset();
    applyStimulus(haz);
    applyStimulus(idle);
    checkC("rstmid.pre", O_STALL, 1'b1);
    rst = 1'b1;
    #1;
    checkC("rstmid.post", O_RUN, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
